// File: rtl/scoreboard_mc_pkg.sv
// scoreboard_mc_pkg
//   Shared types and defaults for the multi-CDB scoreboard.
//   fu_type_t       : functional-unit class requested by decode.
//   SB_FU_TYPE_MAP  : default static class of each FU index.
//   fu_id_width()   : width of an FU index, at least one bit.
package scoreboard_mc_pkg;

   typedef enum logic [2:0] {
      FU_ALU    = 3'd0,
      FU_MUL    = 3'd1,
      FU_DIV    = 3'd2,
      FU_LOAD   = 3'd3,
      FU_BRANCH = 3'd4
   } fu_type_t;

   localparam int unsigned SB_NUM_FU  = 8;
   localparam int unsigned SB_NUM_REG = 32;
   localparam int unsigned REG_IDX_W  = 5;

   localparam fu_type_t SB_FU_TYPE_MAP [SB_NUM_FU] =
      '{FU_ALU, FU_ALU, FU_ALU, FU_MUL, FU_DIV, FU_LOAD, FU_LOAD, FU_BRANCH};

   function automatic int unsigned fu_id_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/sb_rr_multi_grant.sv
// sb_rr_multi_grant
//   Round-robin arbiter issuing up to NUM_GNT grants per cycle out of
//   NUM_REQ requests. The search starts at the internal pointer and wraps;
//   the pointer moves to one past the last granted index.
//   clk, rst : clock, synchronous active-high reset (pointer -> 0)
//   req_i    : request vector
//   gnt_o    : grant vector, at most NUM_GNT bits set
module sb_rr_multi_grant #(
   parameter  int unsigned NUM_REQ = 8,
   parameter  int unsigned NUM_GNT = 2,
   localparam int unsigned PTR_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [NUM_REQ-1:0] req_i,
   output logic [NUM_REQ-1:0] gnt_o
);

   logic [PTR_W-1:0] ptr_q, ptr_d;

   always_comb begin
      int unsigned      n;
      int unsigned      pos;
      logic [PTR_W-1:0] idx;
      gnt_o = '0;
      ptr_d = ptr_q;
      n     = 0;
      pos   = 0;
      idx   = '0;
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
         pos = 32'(ptr_q) + k;
         if (pos >= NUM_REQ) pos = pos - NUM_REQ;
         idx = PTR_W'(pos);
         if (req_i[idx] && (n < NUM_GNT)) begin
            gnt_o[idx] = 1'b1;
            n          = n + 1;
            ptr_d      = (pos + 1 == NUM_REQ) ? '0 : PTR_W'(pos + 1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) ptr_q <= '0;
      else     ptr_q <= ptr_d;
   end

endmodule

// File: rtl/scoreboard_mc.sv
// scoreboard_mc
//   Control-only Thornton scoreboard for NUM_FU units with operand-read
//   acknowledge and WAR-checked write permission for NUM_CDB writers/cycle.
//   clk, rst, flush : clock, synchronous active-high reset / flush
//   iss_*           : decoded instruction in; iss_ready = dequeue,
//                     iss_fu_onehot = receiving unit
//   fu_done_exec    : unit holds a finished result (level)
//   fu_rd_ack       : unit consumed its operands this cycle
//   fu_opnd_ready   : unit may read the register file
//   fu_wr_grant     : unit may write its result this cycle
//   reg_pending     : register awaiting a producer
//   busy_count      : number of busy units
module scoreboard_mc
   import scoreboard_mc_pkg::*;
#(
   parameter  int unsigned NUM_FU                   = SB_NUM_FU,
   parameter  int unsigned NUM_CDB                  = 2,
   parameter  int unsigned NUM_REG                  = SB_NUM_REG,
   parameter  fu_type_t    FU_TYPE_MAP [NUM_FU]     = SB_FU_TYPE_MAP,
   localparam int unsigned FU_ID_W                  = fu_id_width(NUM_FU),
   localparam int unsigned CNT_W                    = $clog2(NUM_FU + 1)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 flush,
   input  logic                 iss_valid,
   input  fu_type_t             iss_type,
   input  logic [REG_IDX_W-1:0] iss_rd,
   input  logic [REG_IDX_W-1:0] iss_rs1,
   input  logic [REG_IDX_W-1:0] iss_rs2,
   output logic                 iss_ready,
   output logic [NUM_FU-1:0]    iss_fu_onehot,
   input  logic [NUM_FU-1:0]    fu_done_exec,
   input  logic [NUM_FU-1:0]    fu_rd_ack,
   output logic [NUM_FU-1:0]    fu_opnd_ready,
   output logic [NUM_FU-1:0]    fu_wr_grant,
   output logic [NUM_REG-1:0]   reg_pending,
   output logic [CNT_W-1:0]     busy_count
);

   typedef logic [FU_ID_W-1:0] fu_id_t;

   typedef struct packed {
      logic                 busy;
      logic [REG_IDX_W-1:0] fi;
      logic [REG_IDX_W-1:0] fj;
      logic [REG_IDX_W-1:0] fk;
      fu_id_t               qj;
      fu_id_t               qk;
      logic                 rj;
      logic                 rk;
      logic                 read_done;
   } sb_fu_entry_t;

   sb_fu_entry_t       ent_q [NUM_FU];
   sb_fu_entry_t       ent_d [NUM_FU];
   logic [NUM_REG-1:0] pend_q, pend_d;
   fu_id_t             owner_q [NUM_REG];
   fu_id_t             owner_d [NUM_REG];

   logic [NUM_FU-1:0]  cand, grant;
   logic               sel_found, iss_fire, src1_rdy, src2_rdy;
   fu_id_t             sel_idx;
   logic               srst;

   assign srst = rst | flush;

   // Write candidates: result held, operands read, no reader still needs Fi.
   always_comb begin
      logic war;
      cand = '0;
      war  = 1'b0;
      for (int unsigned i = 0; i < NUM_FU; i++) begin
         war = 1'b0;
         for (int unsigned j = 0; j < NUM_FU; j++) begin
            if (j != i && ent_q[j].busy && ent_q[i].fi != '0 &&
                ((ent_q[j].fj == ent_q[i].fi && ent_q[j].rj) ||
                 (ent_q[j].fk == ent_q[i].fi && ent_q[j].rk)))
               war = 1'b1;
         end
         cand[i] = ent_q[i].busy & ent_q[i].read_done & fu_done_exec[i] & ~war;
      end
   end

   sb_rr_multi_grant #(
      .NUM_REQ (NUM_FU),
      .NUM_GNT (NUM_CDB)
   ) u_rr (
      .clk   (clk),
      .rst   (srst),
      .req_i (cand),
      .gnt_o (grant)
   );

   assign fu_wr_grant = grant;
   assign reg_pending = pend_q;

   always_comb begin
      for (int unsigned i = 0; i < NUM_FU; i++)
         fu_opnd_ready[i] = ent_q[i].busy & ent_q[i].rj & ent_q[i].rk & ~ent_q[i].read_done;
   end

   always_comb begin
      busy_count = '0;
      for (int unsigned i = 0; i < NUM_FU; i++)
         busy_count = busy_count + CNT_W'(ent_q[i].busy);
   end

   // Issue: lowest free unit of the requested class; WAW stalls on registered pending.
   always_comb begin
      sel_found = 1'b0;
      sel_idx   = '0;
      for (int unsigned i = 0; i < NUM_FU; i++) begin
         if (!sel_found && !ent_q[i].busy && FU_TYPE_MAP[i] == iss_type) begin
            sel_found = 1'b1;
            sel_idx   = fu_id_t'(i);
         end
      end
      iss_fire  = iss_valid & sel_found & ((iss_rd == '0) | ~pend_q[iss_rd]) & ~srst;
      iss_ready = iss_fire;
      for (int unsigned i = 0; i < NUM_FU; i++)
         iss_fu_onehot[i] = iss_fire & (sel_idx == fu_id_t'(i));
      // A producer granted this cycle counts as already released.
      src1_rdy = (iss_rs1 == '0) | ~pend_q[iss_rs1] | grant[owner_q[iss_rs1]];
      src2_rdy = (iss_rs2 == '0) | ~pend_q[iss_rs2] | grant[owner_q[iss_rs2]];
   end

   always_comb begin
      ent_d   = ent_q;
      pend_d  = pend_q;
      owner_d = owner_q;
      for (int unsigned i = 0; i < NUM_FU; i++) begin
         if (grant[i]) begin
            ent_d[i].busy = 1'b0;
            if (ent_q[i].fi != '0 && owner_q[ent_q[i].fi] == fu_id_t'(i))
               pend_d[ent_q[i].fi] = 1'b0;
         end
      end
      // Wake-up is limited to waiting sources of unread units: Q fields are
      // stale once R is set, and R must stay clear after the read.
      for (int unsigned j = 0; j < NUM_FU; j++) begin
         for (int unsigned i = 0; i < NUM_FU; i++) begin
            if (grant[i] && ent_q[j].busy && !ent_q[j].read_done) begin
               if (!ent_q[j].rj && ent_q[j].qj == fu_id_t'(i)) ent_d[j].rj = 1'b1;
               if (!ent_q[j].rk && ent_q[j].qk == fu_id_t'(i)) ent_d[j].rk = 1'b1;
            end
         end
      end
      for (int unsigned i = 0; i < NUM_FU; i++) begin
         if (fu_rd_ack[i] && fu_opnd_ready[i]) begin
            ent_d[i].read_done = 1'b1;
            ent_d[i].rj        = 1'b0;
            ent_d[i].rk        = 1'b0;
         end
      end
      if (iss_fire) begin
         ent_d[sel_idx] = '{busy: 1'b1, fi: iss_rd, fj: iss_rs1, fk: iss_rs2,
                            qj: owner_q[iss_rs1], qk: owner_q[iss_rs2],
                            rj: src1_rdy, rk: src2_rdy, read_done: 1'b0};
         if (iss_rd != '0) begin
            pend_d[iss_rd]  = 1'b1;
            owner_d[iss_rd] = sel_idx;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (srst) begin
         ent_q   <= '{default: '0};
         pend_q  <= '0;
         owner_q <= '{default: '0};
      end else begin
         ent_q   <= ent_d;
         pend_q  <= pend_d;
         owner_q <= owner_d;
      end
   end

   a_rd_ack_ready : assert property (@(posedge clk) disable iff (srst)
      ((fu_rd_ack & ~fu_opnd_ready) == '0));

endmodule

// File: tb/tb_scoreboard_mc.sv
module tb_scoreboard_mc;
   import scoreboard_mc_pkg::*;

   logic        clk, rst, flush, iss_valid, iss_ready;
   fu_type_t    iss_type;
   logic [4:0]  iss_rd, iss_rs1, iss_rs2;
   logic [7:0]  iss_fu_onehot, fu_done_exec, fu_rd_ack, fu_opnd_ready, fu_wr_grant;
   logic [31:0] reg_pending;
   logic [3:0]  busy_count;

   int checks = 0;
   int failures = 0;

   scoreboard_mc #(.NUM_FU(8), .NUM_CDB(2), .NUM_REG(32)) dut (
      .clk           (clk),
      .rst           (rst),
      .flush         (flush),
      .iss_valid     (iss_valid),
      .iss_type      (iss_type),
      .iss_rd        (iss_rd),
      .iss_rs1       (iss_rs1),
      .iss_rs2       (iss_rs2),
      .iss_ready     (iss_ready),
      .iss_fu_onehot (iss_fu_onehot),
      .fu_done_exec  (fu_done_exec),
      .fu_rd_ack     (fu_rd_ack),
      .fu_opnd_ready (fu_opnd_ready),
      .fu_wr_grant   (fu_wr_grant),
      .reg_pending   (reg_pending),
      .busy_count    (busy_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   typedef struct {
      logic       iv;
      fu_type_t   ty;
      logic [4:0] rd, rs1, rs2;
      logic [7:0] dn, ak;
      logic       e_rdy;
      logic [7:0] e_oh, e_ordy, e_gnt;
      logic [3:0] e_bc;
      logic [31:0] e_pend;
   } vec_t;

   vec_t tbl[$];

   function automatic vec_t mk(logic iv, fu_type_t ty, int rd, int rs1, int rs2,
                               logic [7:0] dn, logic [7:0] ak, logic rdy,
                               logic [7:0] oh, logic [7:0] ordy, logic [7:0] gnt,
                               int bc, logic [31:0] pend);
      vec_t v;
      v.iv = iv; v.ty = ty; v.rd = 5'(rd); v.rs1 = 5'(rs1); v.rs2 = 5'(rs2);
      v.dn = dn; v.ak = ak; v.e_rdy = rdy; v.e_oh = oh; v.e_ordy = ordy;
      v.e_gnt = gnt; v.e_bc = 4'(bc); v.e_pend = pend;
      return v;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=0x%0h required=0x%0h", nm, act, exp);
      end
   endtask

   task automatic drive(input logic iv, input fu_type_t ty, input int rd, input int rs1,
                        input int rs2, input logic [7:0] dn, input logic [7:0] ak,
                        input logic fl);
      iss_valid = iv; iss_type = ty; iss_rd = 5'(rd); iss_rs1 = 5'(rs1); iss_rs2 = 5'(rs2);
      fu_done_exec = dn; fu_rd_ack = ak; flush = fl;
      #3;
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic idle;
      drive(1'b0, FU_ALU, 0, 0, 0, 8'h00, 8'h00, 1'b0);
   endtask

   initial begin
      rst = 1'b1; flush = 1'b0; iss_valid = 1'b0; iss_type = FU_ALU;
      iss_rd = '0; iss_rs1 = '0; iss_rs2 = '0; fu_done_exec = '0; fu_rd_ack = '0;

      //              iv  type       rd rs1 rs2 done  ack  rdy  oh    ordy  gnt  bc pend
      // reset state + single ADD x3,x1,x2
      tbl.push_back(mk(0, FU_ALU,    0, 0, 0, 8'h00, 8'h00, 0, 8'h00, 8'h00, 8'h00, 0, 32'h0));
      tbl.push_back(mk(1, FU_ALU,    3, 1, 2, 8'h00, 8'h00, 1, 8'h01, 8'h00, 8'h00, 0, 32'h0));
      tbl.push_back(mk(0, FU_ALU,    0, 0, 0, 8'h00, 8'h00, 0, 8'h00, 8'h01, 8'h00, 1, 32'h8));
      tbl.push_back(mk(0, FU_ALU,    0, 0, 0, 8'h01, 8'h01, 0, 8'h00, 8'h01, 8'h00, 1, 32'h8));
      tbl.push_back(mk(0, FU_ALU,    0, 0, 0, 8'h01, 8'h00, 0, 8'h00, 8'h00, 8'h01, 1, 32'h8));
      tbl.push_back(mk(0, FU_ALU,    0, 0, 0, 8'h00, 8'h00, 0, 8'h00, 8'h00, 8'h00, 0, 32'h0));
      // RAW: DIV x5 then ADD x6,x5,x1
      tbl.push_back(mk(1, FU_DIV,    5, 0, 0, 8'h00, 8'h00, 1, 8'h10, 8'h00, 8'h00, 0, 32'h0));
      tbl.push_back(mk(1, FU_ALU,    6, 5, 1, 8'h00, 8'h00, 1, 8'h01, 8'h10, 8'h00, 1, 32'h20));
      tbl.push_back(mk(0, FU_ALU,    0, 0, 0, 8'h00, 8'h10, 0, 8'h00, 8'h10, 8'h00, 2, 32'h60));
      tbl.push_back(mk(0, FU_ALU,    0, 0, 0, 8'h10, 8'h00, 0, 8'h00, 8'h00, 8'h10, 2, 32'h60));
      tbl.push_back(mk(0, FU_ALU,    0, 0, 0, 8'h00, 8'h00, 0, 8'h00, 8'h01, 8'h00, 1, 32'h40));
      tbl.push_back(mk(0, FU_ALU,    0, 0, 0, 8'h00, 8'h01, 0, 8'h00, 8'h01, 8'h00, 1, 32'h40));
      tbl.push_back(mk(0, FU_ALU,    0, 0, 0, 8'h01, 8'h00, 0, 8'h00, 8'h00, 8'h01, 1, 32'h40));
      tbl.push_back(mk(0, FU_ALU,    0, 0, 0, 8'h00, 8'h00, 0, 8'h00, 8'h00, 8'h00, 0, 32'h0));
      // WAR: ADD x7,x8,x9 then MUL x8
      tbl.push_back(mk(1, FU_ALU,    7, 8, 9, 8'h00, 8'h00, 1, 8'h01, 8'h00, 8'h00, 0, 32'h0));
      tbl.push_back(mk(1, FU_MUL,    8, 0, 0, 8'h00, 8'h00, 1, 8'h08, 8'h01, 8'h00, 1, 32'h80));
      tbl.push_back(mk(0, FU_ALU,    0, 0, 0, 8'h00, 8'h08, 0, 8'h00, 8'h09, 8'h00, 2, 32'h180));
      tbl.push_back(mk(0, FU_ALU,    0, 0, 0, 8'h08, 8'h00, 0, 8'h00, 8'h01, 8'h00, 2, 32'h180));
      tbl.push_back(mk(0, FU_ALU,    0, 0, 0, 8'h08, 8'h01, 0, 8'h00, 8'h01, 8'h00, 2, 32'h180));
      tbl.push_back(mk(0, FU_ALU,    0, 0, 0, 8'h08, 8'h00, 0, 8'h00, 8'h00, 8'h08, 2, 32'h180));
      tbl.push_back(mk(0, FU_ALU,    0, 0, 0, 8'h00, 8'h00, 0, 8'h00, 8'h00, 8'h00, 1, 32'h80));
      tbl.push_back(mk(0, FU_ALU,    0, 0, 0, 8'h01, 8'h00, 0, 8'h00, 8'h00, 8'h01, 1, 32'h80));
      tbl.push_back(mk(0, FU_ALU,    0, 0, 0, 8'h00, 8'h00, 0, 8'h00, 8'h00, 8'h00, 0, 32'h0));
      // WAW: MUL x4 pending, ALU rd=4 stalls until the cycle after the grant
      tbl.push_back(mk(1, FU_MUL,    4, 0, 0, 8'h00, 8'h00, 1, 8'h08, 8'h00, 8'h00, 0, 32'h0));
      tbl.push_back(mk(1, FU_ALU,    4, 0, 0, 8'h00, 8'h00, 0, 8'h00, 8'h08, 8'h00, 1, 32'h10));
      tbl.push_back(mk(1, FU_ALU,    4, 0, 0, 8'h00, 8'h08, 0, 8'h00, 8'h08, 8'h00, 1, 32'h10));
      tbl.push_back(mk(1, FU_ALU,    4, 0, 0, 8'h08, 8'h00, 0, 8'h00, 8'h00, 8'h08, 1, 32'h10));
      tbl.push_back(mk(1, FU_ALU,    4, 0, 0, 8'h00, 8'h00, 1, 8'h01, 8'h00, 8'h00, 0, 32'h0));
      tbl.push_back(mk(0, FU_ALU,    0, 0, 0, 8'h00, 8'h00, 0, 8'h00, 8'h01, 8'h00, 1, 32'h10));
      tbl.push_back(mk(0, FU_ALU,    0, 0, 0, 8'h00, 8'h01, 0, 8'h00, 8'h01, 8'h00, 1, 32'h10));
      tbl.push_back(mk(0, FU_ALU,    0, 0, 0, 8'h01, 8'h00, 0, 8'h00, 8'h00, 8'h01, 1, 32'h10));
      tbl.push_back(mk(0, FU_ALU,    0, 0, 0, 8'h00, 8'h00, 0, 8'h00, 8'h00, 8'h00, 0, 32'h0));
      // Bypass: consumer issues while its producer is granted
      tbl.push_back(mk(1, FU_DIV,    9, 0, 0, 8'h00, 8'h00, 1, 8'h10, 8'h00, 8'h00, 0, 32'h0));
      tbl.push_back(mk(0, FU_ALU,    0, 0, 0, 8'h00, 8'h10, 0, 8'h00, 8'h10, 8'h00, 1, 32'h200));
      tbl.push_back(mk(1, FU_ALU,   10, 9, 0, 8'h10, 8'h00, 1, 8'h01, 8'h00, 8'h10, 1, 32'h200));
      tbl.push_back(mk(0, FU_ALU,    0, 0, 0, 8'h00, 8'h00, 0, 8'h00, 8'h01, 8'h00, 1, 32'h400));
      tbl.push_back(mk(0, FU_ALU,    0, 0, 0, 8'h00, 8'h01, 0, 8'h00, 8'h01, 8'h00, 1, 32'h400));
      tbl.push_back(mk(0, FU_ALU,    0, 0, 0, 8'h01, 8'h00, 0, 8'h00, 8'h00, 8'h01, 1, 32'h400));
      tbl.push_back(mk(0, FU_ALU,    0, 0, 0, 8'h00, 8'h00, 0, 8'h00, 8'h00, 8'h00, 0, 32'h0));

      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;

      for (int i = 0; i < tbl.size(); i++) begin
         drive(tbl[i].iv, tbl[i].ty, int'(tbl[i].rd), int'(tbl[i].rs1), int'(tbl[i].rs2),
               tbl[i].dn, tbl[i].ak, 1'b0);
         chk($sformatf("v%0d.iss_ready", i), 32'(iss_ready),     32'(tbl[i].e_rdy));
         chk($sformatf("v%0d.onehot", i),    32'(iss_fu_onehot), 32'(tbl[i].e_oh));
         chk($sformatf("v%0d.opnd_rdy", i),  32'(fu_opnd_ready), 32'(tbl[i].e_ordy));
         chk($sformatf("v%0d.wr_grant", i),  32'(fu_wr_grant),   32'(tbl[i].e_gnt));
         chk($sformatf("v%0d.busy_cnt", i),  32'(busy_count),    32'(tbl[i].e_bc));
         chk($sformatf("v%0d.pending", i),   reg_pending,        tbl[i].e_pend);
         tick();
      end

      // Round-robin: reset pointer, three ALUs done together
      idle(); rst = 1'b1; tick(); rst = 1'b0;
      drive(1, FU_ALU, 11, 0, 0, 8'h00, 8'h00, 0); chk("rr.iss0", 32'(iss_fu_onehot), 32'h01); tick();
      drive(1, FU_ALU, 12, 0, 0, 8'h00, 8'h00, 0); chk("rr.iss1", 32'(iss_fu_onehot), 32'h02); tick();
      drive(1, FU_ALU, 13, 0, 0, 8'h00, 8'h00, 0); chk("rr.iss2", 32'(iss_fu_onehot), 32'h04); tick();
      drive(0, FU_ALU, 0, 0, 0, 8'h00, 8'h07, 0);  chk("rr.ordy", 32'(fu_opnd_ready), 32'h07); tick();
      drive(0, FU_ALU, 0, 0, 0, 8'h07, 8'h00, 0);  chk("rr.gnt_a", 32'(fu_wr_grant), 32'h03); tick();
      drive(0, FU_ALU, 0, 0, 0, 8'h04, 8'h00, 0);  chk("rr.gnt_b", 32'(fu_wr_grant), 32'h04); tick();
      idle(); chk("rr.bc0", 32'(busy_count), 32'h0); tick();
      // Pointer now at 3: requests {0,1,3} must yield {3,0} first
      drive(1, FU_ALU, 11, 0, 0, 8'h00, 8'h00, 0); chk("rr2.iss0", 32'(iss_fu_onehot), 32'h01); tick();
      drive(1, FU_ALU, 12, 0, 0, 8'h00, 8'h00, 0); chk("rr2.iss1", 32'(iss_fu_onehot), 32'h02); tick();
      drive(1, FU_MUL, 14, 0, 0, 8'h00, 8'h00, 0); chk("rr2.iss3", 32'(iss_fu_onehot), 32'h08); tick();
      drive(0, FU_ALU, 0, 0, 0, 8'h00, 8'h0B, 0);  chk("rr2.ordy", 32'(fu_opnd_ready), 32'h0B); tick();
      drive(0, FU_ALU, 0, 0, 0, 8'h0B, 8'h00, 0);  chk("rr2.gnt_a", 32'(fu_wr_grant), 32'h09); tick();
      drive(0, FU_ALU, 0, 0, 0, 8'h02, 8'h00, 0);  chk("rr2.gnt_b", 32'(fu_wr_grant), 32'h02); tick();
      idle(); chk("rr2.bc0", 32'(busy_count), 32'h0); tick();

      // Structural stall: single BRANCH unit
      drive(1, FU_BRANCH, 0, 0, 0, 8'h00, 8'h00, 0); chk("br.iss", 32'(iss_fu_onehot), 32'h80); tick();
      drive(1, FU_BRANCH, 0, 0, 0, 8'h00, 8'h00, 0); chk("br.stall", 32'(iss_ready), 32'h0); tick();
      drive(0, FU_ALU, 0, 0, 0, 8'h00, 8'h80, 0);    chk("br.ordy", 32'(fu_opnd_ready), 32'h80); tick();
      drive(0, FU_ALU, 0, 0, 0, 8'h80, 8'h00, 0);    chk("br.gnt", 32'(fu_wr_grant), 32'h80); tick();
      idle(); chk("br.pend", reg_pending, 32'h0); tick();

      // Flush with five busy units and x1..x5 pending
      drive(1, FU_ALU, 1, 0, 0, 8'h00, 8'h00, 0); chk("fl.iss0", 32'(iss_fu_onehot), 32'h01); tick();
      drive(1, FU_ALU, 2, 0, 0, 8'h00, 8'h00, 0); chk("fl.iss1", 32'(iss_fu_onehot), 32'h02); tick();
      drive(1, FU_ALU, 3, 0, 0, 8'h00, 8'h00, 0); chk("fl.iss2", 32'(iss_fu_onehot), 32'h04); tick();
      drive(1, FU_MUL, 4, 0, 0, 8'h00, 8'h00, 0); chk("fl.iss3", 32'(iss_fu_onehot), 32'h08); tick();
      drive(1, FU_DIV, 5, 0, 0, 8'h00, 8'h00, 0); chk("fl.iss4", 32'(iss_fu_onehot), 32'h10); tick();
      drive(0, FU_ALU, 0, 0, 0, 8'h00, 8'h1F, 0);
      chk("fl.bc5", 32'(busy_count), 32'h5);
      chk("fl.pend5", reg_pending, 32'h3E);
      tick();
      drive(1, FU_ALU, 6, 0, 0, 8'h1F, 8'h00, 1); tick();
      drive(0, FU_ALU, 0, 0, 0, 8'h1F, 8'h00, 0);
      chk("fl.bc", 32'(busy_count), 32'h0);
      chk("fl.pend", reg_pending, 32'h0);
      chk("fl.gnt", 32'(fu_wr_grant), 32'h0);
      chk("fl.ordy", 32'(fu_opnd_ready), 32'h0);
      tick();
      drive(1, FU_ALU, 6, 0, 0, 8'h00, 8'h00, 0); chk("fl.reiss", 32'(iss_fu_onehot), 32'h01); tick();
      idle();
      chk("fl.pend6", reg_pending, 32'h40);
      tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
